uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/uart_tx_arb.sv | 95 +++++++++
 tb/tb_uart_tx_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and byte width for uart_tx_arb
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_BUSY, S_XMIT, S_GAP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin search starting one past last, one-hot grant plus index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    grant = '0;
    idx = '0;
    any = |req;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin byte arbiter feeding one UART transmitter; UART_ARB_LOCK_EN enables packet locking
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_TICKS = 1,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic                      boud_tick,
  output logic [IW-1:0]             grant_id,
  output logic                      busy
);
  state_t r_state, w_next;
  logic [7:0] r_gap, w_gap;
  logic [IW-1:0] r_last, w_idx;
  logic [NUM_REQ-1:0] w_req, w_grant;
  logic w_any, w_accept;
`ifdef UART_ARB_LOCK_EN
  logic r_locked;
  logic [IW-1:0] r_lock_id;
  assign w_req = r_locked ? req_valid & (NUM_REQ'(1) << r_lock_id) : req_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= 1'b0;
      r_lock_id <= '0;
    end else if (w_accept) begin
      r_locked <= !req_last[w_idx];
      r_lock_id <= w_idx;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_req = req_valid;
`endif
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(w_req),
    .last(r_last),
    .grant(w_grant),
    .idx(w_idx),
    .any(w_any)
  );
  assign w_accept = (r_state == S_IDLE) && en && w_any && !rst;
  assign req_ready = w_accept ? w_grant : '0;
  assign tx_start = r_state == S_START;
  assign busy = r_state != S_IDLE;
  always_comb begin
    w_next = r_state;
    w_gap = r_gap;
    case (r_state)
      S_IDLE:      w_next = w_accept ? S_START : S_IDLE;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: w_next = tx_busy ? S_XMIT : S_WAIT_BUSY;
      S_XMIT: if (!tx_busy) begin
        w_next = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
        w_gap = 8'(GAP_TICKS);
      end
      S_GAP: if (r_gap == 8'd0) w_next = S_IDLE;
      else if (boud_tick) begin
        w_gap = r_gap - 8'd1;
        w_next = (r_gap == 8'd1) ? S_IDLE : S_GAP;
      end
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap <= '0;
      tx_data <= '0;
      grant_id <= '0;
      r_last <= IW'(NUM_REQ - 1);
    end else begin
      r_gap <= w_gap;
      if (w_accept) begin
        tx_data <= req_data[w_idx*BYTE_W +: BYTE_W];
        grant_id <= w_idx;
        r_last <= w_idx;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: table-driven and scoreboard bench for uart_tx_arb
module tb_uart_tx_arb;
  localparam int GAP = 3;
  localparam int FRAME = 5;
  logic clk = 0, rst = 1, en = 1;
  logic [3:0] req_valid = '0, req_last = '1, req_ready;
  logic [31:0] req_data = '0;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  logic tx_start, tx_busy, boud_tick, busy;
  logic xm_busy = 0, man_busy = 0, auto_x = 1, tick = 0;
  typedef struct {int id; logic [7:0] d;} exp_t;
  typedef struct {logic [3:0] v; int id;} vec_t;
  exp_t q[$];
  int checks = 0, errors = 0, acc_cnt = 0, mon_id = 0, due_id = 0, tcnt = 0;
  bit mon_acc = 0, start_due = 0, armed = 0, last_tick = 0, prev_txb = 0, strict = 0;
  logic [7:0] due_d = '0;
  assign tx_busy = xm_busy | man_busy;
  assign boud_tick = tick;
  always #5 clk = ~clk;
  uart_tx_arb #(.NUM_REQ(4), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .boud_tick(boud_tick), .grant_id(grant_id), .busy(busy)
  );
  initial forever begin
    repeat (2) @(posedge clk);
    #1 tick = 1;
    @(posedge clk);
    #1 tick = 0;
  end
  // transmitter model: busy rises the cycle after tx_start and lasts FRAME cycles
  initial forever begin
    @(negedge clk);
    if (auto_x && tx_start === 1'b1) begin
      @(posedge clk);
      #1 xm_busy = 1;
      repeat (FRAME) @(posedge clk);
      #1 xm_busy = 0;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [7:0] dat(input int k, input int i);
    return 8'(32'hA4 + i + k * 16);
  endfunction
  task automatic set_data(input int k);
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = dat(k, i);
  endtask
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    mon_acc = 0;
    if (start_due) begin
      chk("tx_start", 32'(tx_start), 1);
      chk("tx_data", 32'(tx_data), 32'(due_d));
      chk("grant_id", 32'(grant_id), due_id);
      start_due = 0;
    end else if (tx_start === 1'b1) chk("spurious_tx_start", 32'(tx_start), 0);
    if (req_ready !== 4'b0) begin
      mon_acc = 1;
      acc_cnt++;
      for (int i = 0; i < 4; i++) if (req_ready[i]) mon_id = i;
      if (q.size() == 0) chk("unexpected_grant", 32'(req_ready), 0);
      else begin
        e = q.pop_front();
        chk("req_ready", 32'(req_ready), 32'(1) << e.id);
        chk("busy_at_grant", 32'(busy), 0);
        if (armed && strict) begin
          chk("gap_ticks", tcnt, GAP);
          chk("gap_tight", 32'(last_tick), 1);
        end else if (armed) chk("gap_min", 32'(tcnt >= GAP), 1);
        start_due = 1;
        due_d = e.d;
        due_id = e.id;
      end
      armed = 0;
    end
    if (prev_txb && !tx_busy) begin
      armed = 1;
      tcnt = 0;
      last_tick = 0;
    end else begin
      if (boud_tick) tcnt++;
      last_tick = boud_tick;
    end
    prev_txb = tx_busy;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_acc(input int n, input int budget);
    int t;
    t = acc_cnt + n;
    for (int c = 0; c < budget && acc_cnt < t; c++) cyc();
    chk("accept_timeout", 32'(acc_cnt >= t), 1);
  endtask
  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      cyc();
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask
  task automatic do_reset();
    rst = 1;
    req_valid = '0;
    en = 1;
    man_busy = 0;
    repeat (2) cyc();
    rst = 0;
    q.delete();
    armed = 0;
    start_due = 0;
  endtask
  task automatic man_frame();
    repeat (2) cyc();
    man_busy = 1;
    repeat (3) cyc();
    man_busy = 0;
    wait_idle(100);
  endtask
  initial begin
    vec_t tv[9];
    int n0, b2;
    tv[0] = '{4'b0010, 1}; tv[1] = '{4'b1111, 2}; tv[2] = '{4'b0011, 0};
    tv[3] = '{4'b1000, 3}; tv[4] = '{4'b0101, 0}; tv[5] = '{4'b0110, 1};
    tv[6] = '{4'b1100, 2}; tv[7] = '{4'b1001, 3}; tv[8] = '{4'b0100, 2};
    repeat (2) cyc();
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 0;
    for (int k = 0; k < 9; k++) begin
      set_data(k);
      req_valid = tv[k].v;
      q.push_back('{tv[k].id, dat(k, tv[k].id)});
      wait_acc(1, 60);
      req_valid = '0;
      wait_idle(100);
    end
    do_reset();
    set_data(10);
    for (int i = 0; i < 5; i++) q.push_back('{i % 4, dat(10, i % 4)});
    strict = 1;
    req_valid = '1;
    wait_acc(5, 400);
    req_valid = '0;
    strict = 0;
    wait_idle(100);
    do_reset();
    req_data = {8'h00, 8'hC0, 8'hB1, 8'hD0};
    q.push_back('{1, 8'hB1});
    req_valid = 4'b0010;
    wait_acc(1, 60);
    req_valid = '0;
    wait_idle(100);
`ifdef UART_ARB_LOCK_EN
    q.push_back('{2, 8'hC0}); q.push_back('{2, 8'hC1}); q.push_back('{2, 8'hC2}); q.push_back('{0, 8'hD0});
`else
    q.push_back('{2, 8'hC0}); q.push_back('{0, 8'hD0}); q.push_back('{2, 8'hC1}); q.push_back('{0, 8'hD0});
`endif
    b2 = 0;
    req_last[2] = 0;
    req_valid = 4'b0101;
    n0 = acc_cnt;
    for (int c = 0; c < 800 && acc_cnt < n0 + 4; c++) begin
      cyc();
      if (mon_acc && mon_id == 2) begin
        b2++;
        req_data[23:16] = 8'hC0 + 8'(b2);
        req_last[2] = (b2 == 2);
        if (b2 == 3) req_valid[2] = 0;
      end
    end
    req_valid = '0;
    chk("lock_accepts", acc_cnt - n0, 4);
    wait_idle(100);
    req_last = '1;
    do_reset();
    set_data(11);
    q.push_back('{0, dat(11, 0)});
    req_valid = 4'b0001;
    wait_acc(1, 60);
    req_valid = '0;
    for (int c = 0; c < 20 && !tx_busy; c++) cyc();
    cyc();
    en = 0;
    req_valid = '1;
    wait_idle(100);
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("ready_en0", 32'(req_ready), 0);
      chk("busy_en0", 32'(busy), 0);
    end
    q.push_back('{1, dat(11, 1)});
    en = 1;
    cyc();
    chk("en_grant", 32'(mon_acc), 1);
    req_valid = '0;
    wait_idle(100);
    do_reset();
    auto_x = 0;
    set_data(12);
    q.push_back('{0, dat(12, 0)});
    req_valid = 4'b0001;
    wait_acc(1, 60);
    req_valid = '0;
    repeat (6) cyc();
    chk("wait_hold", 32'(busy), 1);
    man_frame();
    do_reset();
    set_data(13);
    q.push_back('{0, dat(13, 0)});
    req_valid = 4'b0001;
    wait_acc(1, 60);
    req_valid = '0;
    cyc();
    rst = 1;
    cyc();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tx_start", 32'(tx_start), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    rst = 0;
    q.push_back('{0, dat(13, 0)});
    req_valid = 4'b0011;
    wait_acc(1, 10);
    req_valid = '0;
    man_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
